spi_slave: RTL and testbench

- SPI slave for SPI mode 0 (CPOL=0, CPHA=0), MSB first, active-low chip select, full duplex, 8-bit frames.
- All SPI inputs are oversampled in the i_clk domain. i_clk must be at least 8x the SPI clock.
- Sits between an external SPI master pin interface and on-chip logic.
- Delivers each received byte with a one-cycle o_rx_done strobe and a one-cycle o_tx_done strobe per transmitted byte.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_slave_if.sv | 48 ++++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_slave.sv | 160 ++++++++++++++++
 tb/tb_spi_slave.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave block: default frame width,
// default synchronizer depth and the frame-level state encoding.
`timescale 1ns/1ps
package spi_pkg;

    localparam int unsigned SPI_DATA_W      = 8;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// Bus bundle for the SPI slave: on-chip byte handshake plus the SPI pins.
//   i_tx_data  : byte to transmit, sampled at frame start / byte boundary
//   o_tx_done  : one-cycle pulse when a byte has been shifted out
//   o_rx_data  : last complete received byte
//   o_rx_done  : one-cycle pulse when o_rx_data was updated
//   i_spi_cs   : chip select, active low, asynchronous
//   i_spi_clk  : SPI clock, idle low, asynchronous
//   i_spi_mosi : master-out data
//   o_spi_miso : slave-out data
// The slave modport is used by spi_slave; the master modport by whatever
// drives the pins and consumes the bytes.
`timescale 1ns/1ps
interface spi_slave_if #(
    parameter int unsigned DATA_W = spi_pkg::SPI_DATA_W
) ();

    logic [DATA_W-1:0] i_tx_data;
    logic              o_tx_done;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_done;
    logic              i_spi_cs;
    logic              i_spi_clk;
    logic              i_spi_mosi;
    logic              o_spi_miso;

    modport slave (
        input  i_tx_data,
        output o_tx_done,
        output o_rx_data,
        output o_rx_done,
        input  i_spi_cs,
        input  i_spi_clk,
        input  i_spi_mosi,
        output o_spi_miso
    );

    modport master (
        output i_tx_data,
        input  o_tx_done,
        input  o_rx_data,
        input  o_rx_done,
        output i_spi_cs,
        output i_spi_clk,
        output i_spi_mosi,
        input  o_spi_miso
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bit with edge detection.
//   clk, rst : system clock, asynchronous active-high reset
//   din      : asynchronous input
//   sync     : synchronized value (registered)
//   rise_c   : sync went 0->1 this cycle (combinational)
//   fall_c   : sync went 1->0 this cycle (combinational)
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    // Synchronizer chain plus one-cycle-delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {SYNC_STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], din};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync   = chain_q[SYNC_STAGES-1];
    assign rise_c = chain_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_c = ~chain_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, full duplex, oversampled in the i_clk domain.
//   i_clk : system clock (at least 8x SCLK)
//   i_rst : asynchronous active-high reset
//   bus   : spi_slave_if.slave (byte handshake + SPI pins)
// Received bytes appear on o_rx_data with an o_rx_done pulse; each shifted-out
// byte gives an o_tx_done pulse and reloads the next byte from i_tx_data.
`timescale 1ns/1ps
module spi_slave #(
    parameter int unsigned DATA_W      = spi_pkg::SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = spi_pkg::SPI_SYNC_STAGES
) (
    input  logic           i_clk,
    input  logic           i_rst,
    spi_slave_if.slave     bus
);

    import spi_pkg::*;

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic cs_sync, cs_rise, cs_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_sync;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    // Bits already received / still to send; the bit on MISO lives in miso_q
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_done_q, rx_done_d;
    logic              tx_done_q, tx_done_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] rx_next;

    // Chip select idles high, so its synchronizer resets to 1
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (i_clk),
        .rst    (i_rst),
        .din    (bus.i_spi_cs),
        .sync   (cs_sync),
        .rise_c (cs_rise),
        .fall_c (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (i_clk),
        .rst    (i_rst),
        .din    (bus.i_spi_clk),
        .sync   (sclk_sync),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    // MOSI needs only the level; same depth keeps it aligned with SCLK
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) mosi_q <= '0;
        else       mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.i_spi_mosi};
    end
    assign mosi_sync = mosi_q[SYNC_STAGES-1];

    logic unused_sclk_level;
    assign unused_sclk_level = sclk_sync;

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            tx_done_q  <= tx_done_d;
            miso_q     <= miso_d;
        end
    end

    // Next-state and datapath logic; cs_rise overrides any SCLK edge
    always_comb begin
        state_d    = state_q;
        rx_cnt_d   = rx_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        tx_done_d  = 1'b0;
        miso_d     = miso_q;
        rx_next    = {rx_shift_q, mosi_sync};

        if (cs_rise) begin
            state_d    = IDLE;
            rx_cnt_d   = '0;
            tx_cnt_d   = '0;
            rx_shift_d = '0;
            miso_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rx_cnt_d = '0;
                    tx_cnt_d = '0;
                    miso_d   = 1'b0;
                    if (cs_fall) begin
                        state_d    = ACTIVE;
                        rx_shift_d = '0;
                        tx_shift_d = bus.i_tx_data[DATA_W-2:0];
                        miso_d     = bus.i_tx_data[DATA_W-1];
                    end
                end
                ACTIVE: begin
                    if (sclk_rise && !cs_sync) begin
                        if (rx_cnt_q == CNT_W'(DATA_W - 1)) begin
                            rx_data_d  = rx_next;
                            rx_done_d  = 1'b1;
                            rx_cnt_d   = '0;
                            rx_shift_d = '0;
                        end else begin
                            rx_shift_d = rx_next[DATA_W-2:0];
                            rx_cnt_d   = rx_cnt_q + CNT_W'(1);
                        end
                    end
                    if (sclk_fall && !cs_sync) begin
                        if (tx_cnt_q == CNT_W'(DATA_W - 1)) begin
                            // Byte boundary: reload so the next byte can follow under the same CS
                            tx_done_d  = 1'b1;
                            tx_cnt_d   = '0;
                            tx_shift_d = bus.i_tx_data[DATA_W-2:0];
                            miso_d     = bus.i_tx_data[DATA_W-1];
                        end else begin
                            miso_d     = tx_shift_q[DATA_W-2];
                            tx_shift_d = {tx_shift_q[DATA_W-3:0], 1'b0};
                            tx_cnt_d   = tx_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.o_rx_data  = rx_data_q;
    assign bus.o_rx_done  = rx_done_q;
    assign bus.o_tx_done  = tx_done_q;
    assign bus.o_spi_miso = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
module tb_spi_slave;

    logic i_clk = 1'b0;
    logic i_rst;

    spi_slave_if bus ();

    spi_slave dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #1 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Observations collected on the falling edge of i_clk
    logic [7:0] rx_q[$];
    int tx_done_cnt = 0;
    int wide_pulses = 0;
    logic rx_prev = 1'b0;
    logic tx_prev = 1'b0;

    always @(negedge i_clk) begin
        if (bus.o_rx_done === 1'b1) rx_q.push_back(bus.o_rx_data);
        if (bus.o_tx_done === 1'b1) tx_done_cnt++;
        if (bus.o_rx_done === 1'b1 && rx_prev === 1'b1) wide_pulses++;
        if (bus.o_tx_done === 1'b1 && tx_prev === 1'b1) wide_pulses++;
        rx_prev = bus.o_rx_done;
        tx_prev = bus.o_tx_done;
    end

    // Reference model: list of bytes the master completed, and pulse count
    logic [7:0] exp_rx[$];
    int exp_tx_done = 0;
    logic [7:0] exp_last_rx = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master side: drive n bits MSB first, sample MISO on each SCLK rise
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] miso_b);
        miso_b = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.i_spi_mosi = b[7-i];
            #10;
            bus.i_spi_clk = 1'b1;
            miso_b = {miso_b[6:0], bus.o_spi_miso};
            #10;
            bus.i_spi_clk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b, output logic [7:0] miso_b);
        bus.i_spi_cs = 1'b0;
        #10;
        send_bits(b, 8, miso_b);
        #10;
        bus.i_spi_cs = 1'b1;
        #100;
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_rx.size()));
        if (rx_q.size() == exp_rx.size() && exp_rx.size() > 0)
            check({tag, "_rx_byte"}, 32'(rx_q[$]), 32'(exp_rx[$]));
        check({tag, "_rx_data"}, 32'(bus.o_rx_data), 32'(exp_last_rx));
        check({tag, "_tx_done"}, 32'(tx_done_cnt), 32'(exp_tx_done));
    endtask

    logic [7:0] m, m2, b, tx_cap;
    bit tx_run;
    longint t0;

    initial begin
        i_rst          = 1'b1;
        bus.i_spi_cs   = 1'b1;
        bus.i_spi_clk  = 1'b0;
        bus.i_spi_mosi = 1'b0;
        bus.i_tx_data  = 8'h00;
        #10;
        check("reset_rx_data", 32'(bus.o_rx_data), 32'h0);
        check("reset_rx_done", 32'(bus.o_rx_done), 32'h0);
        check("reset_tx_done", 32'(bus.o_tx_done), 32'h0);
        check("reset_miso",    32'(bus.o_spi_miso), 32'h0);
        i_rst = 1'b0;
        #10;

        // SCLK activity with CS high must be ignored
        bus.i_tx_data = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            bus.i_spi_mosi = 1'b1;
            #10 bus.i_spi_clk = 1'b1;
            #10 bus.i_spi_clk = 1'b0;
        end
        #20;
        check("idle_rx_pulses", 32'(rx_q.size()), 32'h0);
        check("idle_tx_pulses", 32'(tx_done_cnt), 32'h0);
        check("idle_miso", 32'(bus.o_spi_miso), 32'h0);

        // Basic full-duplex frame
        bus.i_tx_data = 8'hA5;
        frame(8'h3C, m);
        exp_rx.push_back(8'h3C); exp_last_rx = 8'h3C; exp_tx_done++;
        check_rx("basic");
        check("basic_miso", 32'(m), 32'hA5);

        // Random frames while i_tx_data changes every 270 ns
        tx_run = 1'b1;
        t0 = $time;
        fork
            begin
                while (tx_run) begin
                    #270;
                    if (tx_run) bus.i_tx_data = 8'($urandom);
                end
            end
        join_none
        for (int f = 0; f < 20; f++) begin
            b = 8'($urandom);
            // Keep frame start clear of a pending i_tx_data change
            while ((($time - t0) % 270) >= 256 || (($time - t0) % 270) < 2) #2;
            tx_cap = bus.i_tx_data;
            frame(b, m);
            exp_rx.push_back(b); exp_last_rx = b; exp_tx_done++;
            check_rx("rand");
            check("rand_miso", 32'(m), 32'(tx_cap));
        end
        tx_run = 1'b0;
        #300;

        // Partial frame: 5 bits then CS released
        bus.i_tx_data = 8'h96;
        bus.i_spi_cs = 1'b0;
        #10;
        send_bits(8'hFF, 5, m);
        #10;
        bus.i_spi_cs = 1'b1;
        #100;
        check_rx("partial");
        bus.i_tx_data = 8'hC3;
        frame(8'h81, m);
        exp_rx.push_back(8'h81); exp_last_rx = 8'h81; exp_tx_done++;
        check_rx("after_partial");
        check("after_partial_miso", 32'(m), 32'hC3);

        // Two bytes under one CS; second TX byte taken at the 8th fall
        bus.i_tx_data = 8'h5E;
        bus.i_spi_cs = 1'b0;
        #12;
        bus.i_tx_data = 8'hB7;
        send_bits(8'h12, 8, m);
        send_bits(8'h34, 8, m2);
        #10;
        bus.i_spi_cs = 1'b1;
        #100;
        exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
        exp_last_rx = 8'h34; exp_tx_done += 2;
        check_rx("b2b");
        if (rx_q.size() >= 2) check("b2b_first_rx", 32'(rx_q[rx_q.size()-2]), 32'h12);
        check("b2b_miso0", 32'(m), 32'h5E);
        check("b2b_miso1", 32'(m2), 32'hB7);

        // Reset in the middle of a frame
        bus.i_tx_data = 8'h77;
        bus.i_spi_cs = 1'b0;
        #10;
        send_bits(8'hAA, 4, m);
        i_rst = 1'b1;
        bus.i_spi_cs = 1'b1;
        #10;
        check("midrst_rx_data", 32'(bus.o_rx_data), 32'h0);
        check("midrst_rx_done", 32'(bus.o_rx_done), 32'h0);
        check("midrst_tx_done", 32'(bus.o_tx_done), 32'h0);
        check("midrst_miso",    32'(bus.o_spi_miso), 32'h0);
        i_rst = 1'b0;
        exp_last_rx = 8'h00;
        #20;
        bus.i_tx_data = 8'hE7;
        frame(8'h5A, m);
        exp_rx.push_back(8'h5A); exp_last_rx = 8'h5A; exp_tx_done++;
        check_rx("after_rst");
        check("after_rst_miso", 32'(m), 32'hE7);

        check("pulse_width", 32'(wide_pulses), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
